host_mat_loader: RTL

// - Host-facing writer for the 2x2 matmul path: accepts a byte stream from the host, fills a 4-entry weight

---
 rtl/tpu_pkg.sv | 17 +
 rtl/mat_bank.sv | 57 +++++
 rtl/host_mat_loader.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared types and constants for the 2x2 matmul host loader and MMU feeder path.
package tpu_pkg;

  localparam int DATA_W     = 8;
  localparam int N_ELEM     = 4;
  localparam int RUN_CYCLES = 6;
  localparam int MMU_CYC_W  = 3;
  localparam int CNT_W      = $clog2(N_ELEM + 1);
  localparam int IDX_W      = $clog2(N_ELEM);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mat_bank.sv
// N_ELEM x DATA_W register bank filled in arrival order through a saturating
// write count; restart rewrites idx0 and restarts the count at 1.
module mat_bank
  import tpu_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     restart,
  input  logic                     clr_cnt,
  output logic                     full,
  output logic                     full_next,
  output logic [N_ELEM*DATA_W-1:0] entries
);

  logic [DATA_W-1:0] mem_q [N_ELEM];
  logic [DATA_W-1:0] mem_d [N_ELEM];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  assign full = (cnt_q == CNT_W'(N_ELEM));

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (wr_en && restart) begin
      mem_d[0] = wr_data;
      cnt_d    = CNT_W'(1);
    end else if (wr_en && !full) begin
      mem_d[cnt_q[IDX_W-1:0]] = wr_data;
      cnt_d                   = cnt_q + CNT_W'(1);
    end
  end

  // Lets the FSM leave LOAD in the same cycle the final byte lands.
  assign full_next = (cnt_d == CNT_W'(N_ELEM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int k = 0; k < N_ELEM; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_out
    assign entries[gi*DATA_W +: DATA_W] = mem_q[gi];
  end

endmodule

// File: rtl/host_mat_loader.sv
// Host byte-stream writer for the 2x2 MMU: fills weight/input banks, then runs one
// RUN_CYCLES-long MMU sequence. Define WEIGHT_REUSE_EN to keep weights across runs.
module host_mat_loader
  import tpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 host_valid,
  input  logic                 host_sel,
  input  logic [DATA_W-1:0]    host_data,
  output logic                 host_ready,
  output logic [DATA_W-1:0]    weight_0,
  output logic [DATA_W-1:0]    weight_1,
  output logic [DATA_W-1:0]    weight_2,
  output logic [DATA_W-1:0]    weight_3,
  output logic [DATA_W-1:0]    input_0,
  output logic [DATA_W-1:0]    input_1,
  output logic [DATA_W-1:0]    input_2,
  output logic [DATA_W-1:0]    input_3,
  output logic                 mmu_en,
  output logic [MMU_CYC_W-1:0] mmu_cycles,
  output logic                 done,
  output logic                 overflow
);

  state_e                 state_q, state_d;
  logic [MMU_CYC_W-1:0]   run_cnt_q, run_cnt_d;
  logic                   overflow_q, overflow_d;

  logic                   accept, w_byte, i_byte;
  logic                   w_wr, w_restart, w_clr, w_drop;
  logic                   i_wr, i_clr;
  logic                   w_full, w_full_next, i_full, i_full_next;
  logic [N_ELEM*DATA_W-1:0] w_entries, i_entries;

  assign accept = host_valid && (state_q == LOAD);
  assign w_byte = accept && !host_sel;
  assign i_byte = accept && host_sel;

`ifdef WEIGHT_REUSE_EN
  assign w_restart = w_full;
  assign w_wr      = w_byte;
  assign w_drop    = 1'b0;
  assign w_clr     = 1'b0;
`else
  assign w_restart = 1'b0;
  assign w_wr      = w_byte && !w_full;
  assign w_drop    = w_byte && w_full;
  assign w_clr     = (state_q == DONE);
`endif

  assign i_wr  = i_byte && !i_full;
  assign i_clr = (state_q == DONE);

  mat_bank u_weight_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (w_wr),
    .wr_data   (host_data),
    .restart   (w_restart),
    .clr_cnt   (w_clr),
    .full      (w_full),
    .full_next (w_full_next),
    .entries   (w_entries)
  );

  mat_bank u_input_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (i_wr),
    .wr_data   (host_data),
    .restart   (1'b0),
    .clr_cnt   (i_clr),
    .full      (i_full),
    .full_next (i_full_next),
    .entries   (i_entries)
  );

  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    // Any byte offered outside LOAD, or to a full bank that cannot take it, is lost.
    overflow_d = overflow_q
               | (host_valid && (state_q != LOAD))
               | w_drop
               | (i_byte && i_full);
    case (state_q)
      LOAD: begin
        run_cnt_d = '0;
        if (w_full_next && i_full_next) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (run_cnt_q == MMU_CYC_W'(RUN_CYCLES - 1)) begin
          state_d   = DONE;
          run_cnt_d = '0;
        end else begin
          run_cnt_d = run_cnt_q + MMU_CYC_W'(1);
        end
      end
      DONE: begin
        state_d   = LOAD;
        run_cnt_d = '0;
      end
      default: begin
        state_d   = LOAD;
        run_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      run_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign host_ready = (state_q == LOAD);
  assign mmu_en     = (state_q == RUN);
  assign mmu_cycles = mmu_en ? run_cnt_q : '0;
  assign done       = (state_q == DONE);
  assign overflow   = overflow_q;

  assign weight_0 = w_entries[0*DATA_W +: DATA_W];
  assign weight_1 = w_entries[1*DATA_W +: DATA_W];
  assign weight_2 = w_entries[2*DATA_W +: DATA_W];
  assign weight_3 = w_entries[3*DATA_W +: DATA_W];
  assign input_0  = i_entries[0*DATA_W +: DATA_W];
  assign input_1  = i_entries[1*DATA_W +: DATA_W];
  assign input_2  = i_entries[2*DATA_W +: DATA_W];
  assign input_3  = i_entries[3*DATA_W +: DATA_W];

endmodule
